// File: rtl/vr_xmit_pkg.sv
// Shared types and helpers for the valid/ready transmitter.
package vr_xmit_pkg;

  // Link-side sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } xmit_state_e;

  // Width of a counter that must hold values 0..max_val (at least 1 bit)
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int STATS_W = 32;

endpackage

// File: rtl/vr_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
module vr_fifo
  import vr_xmit_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_pop,
  output logic [DATA_WIDTH-1:0]         o_head,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [cnt_width(DEPTH)-1:0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  w_push;
  logic                  w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Write the pushed word into the slot at the write pointer
  // NOTE: the storage array is not reset; level and pointers decide which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Advance pointers (wrapping modulo DEPTH) and track occupancy
  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/vr_transmitter.sv
// Valid/ready link transmitter: FIFO-buffered producer words, one beat at a
// time, programmable idle gap between beats and a sticky stall detector.
// Optional statistics counters are enabled with macro VR_XMIT_STATS_EN.
module vr_transmitter
  import vr_xmit_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int GAP        = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         valid,
  input  logic                         ready,
  output logic [DATA_WIDTH-1:0]        data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         stall_err,
  input  logic                         clr_err
`ifdef VR_XMIT_STATS_EN
  ,
  output logic [STATS_W-1:0]           xfer_count,
  output logic [STATS_W-1:0]           stall_cycles
`endif
);

  localparam int GAP_W   = cnt_width(GAP);
  localparam int STALL_W = cnt_width(TIMEOUT);
  localparam logic [GAP_W-1:0]   GAP_RELOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(TIMEOUT);

  xmit_state_e                     r_state;
  xmit_state_e                     w_state_next;
  logic                            r_valid;
  logic [DATA_WIDTH-1:0]           r_data;
  logic [GAP_W-1:0]                r_gap_cnt;
  logic [STALL_W-1:0]              r_stall_cnt;
  logic                            r_stall_err;
  logic [DATA_WIDTH-1:0]           w_head;
  logic                            w_full;
  logic                            w_empty;
  logic [$clog2(DEPTH+1)-1:0]      w_level;
  logic                            w_push;
  logic                            w_xfer;
  logic                            w_stalled;
  logic                            w_stall_hit;
  logic                            w_load;
  logic                            w_drop;
  logic                            w_gap_load;

  // A full FIFO refuses the producer even if the link pops this cycle
  assign in_ready    = !w_full && rst_n;
  assign w_push      = in_valid && in_ready;
  assign w_xfer      = r_valid && ready;
  assign w_stalled   = r_valid && !ready;
  assign w_stall_hit = (TIMEOUT != 0) && w_stalled && (r_stall_cnt >= STALL_MAX - STALL_W'(1));

  assign valid     = r_valid;
  assign data      = r_data;
  assign level     = w_level;
  assign stall_err = r_stall_err;

  vr_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_load),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; the gap expiry applies the idle rule on the same edge
  // NOTE: combinational blocks use blocking '=' and assign defaults first, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty) w_state_next = ST_SEND;
      ST_SEND: begin
        if (w_xfer) begin
          if (GAP > 0)      w_state_next = ST_GAP;
          else if (w_empty) w_state_next = ST_IDLE;
        end
      end
      ST_GAP:  if (r_gap_cnt == '0) w_state_next = w_empty ? ST_IDLE : ST_SEND;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output decode: load a word from the FIFO head, drop the link word, or arm the gap
  always_comb begin
    w_load     = 1'b0;
    w_drop     = 1'b0;
    w_gap_load = 1'b0;
    case (r_state)
      ST_IDLE: w_load = !w_empty;
      ST_SEND: begin
        if (w_xfer) begin
          if (GAP > 0) begin
            w_drop     = 1'b1;
            w_gap_load = 1'b1;
          end else if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      ST_GAP:  if (r_gap_cnt == '0) w_load = !w_empty;
      default: ;
    endcase
  end

  // Link output register and gap counter; data is forced to zero while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_head;
      end else if (w_drop) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end
      if (w_gap_load)
        r_gap_cnt <= GAP_RELOAD;
      else if (r_state == ST_GAP && r_gap_cnt != '0)
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
    end
  end

  // Stall counter saturates at TIMEOUT; sticky error where set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else begin
      if (TIMEOUT == 0 || !w_stalled)
        r_stall_cnt <= '0;
      else if (r_stall_cnt != STALL_MAX)
        r_stall_cnt <= r_stall_cnt + STALL_W'(1);

      if (w_stall_hit)  r_stall_err <= 1'b1;
      else if (clr_err) r_stall_err <= 1'b0;
    end
  end

`ifdef VR_XMIT_STATS_EN
  logic [STATS_W-1:0] r_xfer_count;
  logic [STATS_W-1:0] r_stall_cycles;

  assign xfer_count   = r_xfer_count;
  assign stall_cycles = r_stall_cycles;

  // Free-running transfer and stall statistics, wrapping, cleared by clr_err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_count   <= '0;
      r_stall_cycles <= '0;
    end else if (clr_err) begin
      r_xfer_count   <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_xfer)    r_xfer_count   <= r_xfer_count + STATS_W'(1);
      if (w_stalled) r_stall_cycles <= r_stall_cycles + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vr_transmitter.sv
// Scoreboard bench for vr_transmitter: one instance with GAP=1 and one with
// GAP=0; monitors pop expected words whenever a link transfer is presented.
module tb_vr_transmitter;

  logic       clk;
  logic       rst_n;

  // Instance with GAP=1
  logic       in_valid, in_ready, valid, ready, stall_err, clr_err;
  logic [7:0] in_data, data;
  logic [2:0] level;

  // Instance with GAP=0
  logic       in_valid0, in_ready0, valid0, ready0, stall_err0, clr_err0;
  logic [7:0] in_data0, data0;
  logic [2:0] level0;

`ifdef VR_XMIT_STATS_EN
  logic [31:0] xfer_count, stall_cycles, xfer_count0, stall_cycles0;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q  [$];
  logic [7:0] sb_q0 [$];
  logic [7:0] mon_exp, mon_exp0;

  logic       t2_exp_v [6];
  logic [7:0] t2_exp_d [6];

  vr_transmitter #(.DATA_WIDTH(8), .DEPTH(4), .GAP(1), .TIMEOUT(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .valid     (valid),
    .ready     (ready),
    .data      (data),
    .level     (level),
    .stall_err (stall_err),
    .clr_err   (clr_err)
`ifdef VR_XMIT_STATS_EN
    ,
    .xfer_count   (xfer_count),
    .stall_cycles (stall_cycles)
`endif
  );

  vr_transmitter #(.DATA_WIDTH(8), .DEPTH(4), .GAP(0), .TIMEOUT(16)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .in_data   (in_data0),
    .valid     (valid0),
    .ready     (ready0),
    .data      (data0),
    .level     (level0),
    .stall_err (stall_err0),
    .clr_err   (clr_err0)
`ifdef VR_XMIT_STATS_EN
    ,
    .xfer_count   (xfer_count0),
    .stall_cycles (stall_cycles0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int which);
    int k;
    k = 0;
    while (k < 200 && ((which == 0) ? sb_q.size() : sb_q0.size()) != 0) begin
      cyc();
      k++;
    end
    check($sformatf("drain_%0d", which), (which == 0) ? sb_q.size() : sb_q0.size(), 0);
  endtask

  // Monitor for the GAP=1 instance: a beat with ready high transfers at the next edge
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got %0h expected no word", data);
      end else begin
        mon_exp = sb_q.pop_front();
        check("sb_data", data, mon_exp);
      end
    end
  end

  // Monitor for the GAP=0 instance
  always @(negedge clk) begin
    if (rst_n && valid0 && ready0) begin
      if (sb_q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb0_extra: got %0h expected no word", data0);
      end else begin
        mon_exp0 = sb_q0.pop_front();
        check("sb0_data", data0, mon_exp0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t2_exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    t2_exp_d = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; ready = 1'b1; clr_err = 1'b0;
    in_valid0 = 1'b0; in_data0 = '0; ready0 = 1'b1; clr_err0 = 1'b0;
    #23 rst_n = 1'b1;
    cyc();

    // Reset state
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_level", level, 0);
    check("rst_stall_err", stall_err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_valid0", valid0, 0);

    // Single words with GAP=1: latency and exactly one idle cycle between beats
    in_valid = 1'b1; in_data = 8'hA5; sb_q.push_back(8'hA5);
    cyc();
    check("t1_valid_lat", valid, 0);
    check("t1_level_1", level, 1);
    in_data = 8'h5A; sb_q.push_back(8'h5A);
    cyc();
    in_valid = 1'b0;
    check("t1_valid_a5", valid, 1);
    check("t1_data_a5", data, 8'hA5);
    cyc();
    check("t1_gap_valid", valid, 0);
    check("t1_gap_data", data, 0);
    check("t1_gap_level", level, 1);
    cyc();
    check("t1_valid_5a", valid, 1);
    check("t1_data_5a", data, 8'h5A);
    check("t1_level_0", level, 0);
    cyc();
    check("t1_end_valid", valid, 0);
    cyc();
    check("t1_idle_valid", valid, 0);
    check("t1_idle_level", level, 0);

    // Backpressure: 5 words fit (4 FIFO + output register), the 6th is refused
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hB0 + 8'(i);
      check($sformatf("t3_in_ready_%0d", i), in_ready, 1);
      sb_q.push_back(8'hB0 + 8'(i));
      cyc();
    end
    check("t3_full_in_ready", in_ready, 0);
    check("t3_full_level", level, 4);
    check("t3_hold_valid", valid, 1);
    check("t3_hold_data", data, 8'hB0);
    in_data = 8'hB5;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("t3_refuse_%0d", i), in_ready, 0);
      check($sformatf("t3_level_%0d", i), level, 4);
      check($sformatf("t3_data_%0d", i), data, 8'hB0);
    end
    in_valid = 1'b0;

    // Stall detection: stall edges started one edge after the output loaded; 6 so far
    for (int i = 0; i < 9; i++) cyc();
    check("t4_err_before", stall_err, 0);
    cyc();
    check("t4_err_set", stall_err, 1);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    check("t4_set_wins", stall_err, 1);
    ready = 1'b1;
    drain(0);
    check("t4_err_sticky", stall_err, 1);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    check("t4_err_cleared", stall_err, 0);
    cyc();
    cyc();

    // Reset mid-SEND drops the word in flight and the buffered words
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC0 + 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    check("t5_pre_level", level, 3);
    check("t5_pre_data", data, 8'hC0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", valid, 0);
    check("t5_rst_data", data, 0);
    check("t5_rst_level", level, 0);
    check("t5_rst_in_ready", in_ready, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check($sformatf("t5_quiet_%0d", i), valid, 0);
    end
    in_valid = 1'b1; in_data = 8'hD7; sb_q.push_back(8'hD7);
    cyc();
    in_valid = 1'b0;
    drain(0);

    // GAP=0: four back-to-back beats
    for (int i = 0; i < 6; i++) begin
      in_valid0 = (i < 4);
      in_data0  = 8'(i + 1);
      if (i < 4) sb_q0.push_back(8'(i + 1));
      cyc();
      check($sformatf("t2_valid_%0d", i), valid0, t2_exp_v[i]);
      check($sformatf("t2_data_%0d", i), data0, t2_exp_d[i]);
    end
    in_valid0 = 1'b0;

`ifdef VR_XMIT_STATS_EN
    // Statistics: 5 transfers with 3 stall cycles
    clr_err0 = 1'b1;
    cyc();
    clr_err0 = 1'b0;
    check("t6_clr_xfer", xfer_count0, 0);
    ready0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid0 = 1'b1;
      in_data0  = 8'hE0 + 8'(i);
      sb_q0.push_back(8'hE0 + 8'(i));
      cyc();
    end
    in_valid0 = 1'b0;
    ready0 = 1'b1;
    drain(1);
    cyc();
    check("t6_xfer_count", xfer_count0, 5);
    check("t6_stall_cycles", stall_cycles0, 3);
    clr_err0 = 1'b1;
    cyc();
    clr_err0 = 1'b0;
    check("t6_xfer_clr", xfer_count0, 0);
    check("t6_stall_clr", stall_cycles0, 0);
`endif

    cyc();
    check("end_sb_empty", sb_q.size(), 0);
    check("end_sb0_empty", sb_q0.size(), 0);
    check("end_valid0_idle", valid0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vr_transmitter.md
Name: vr_transmitter

Overview:
- Upstream stage of the valid/ready receiver: buffers words from a local producer in a small FIFO and presents them one at a time on a valid/ready link.
- Holds data stable until accepted.
- Inserts a programmable idle gap between beats so receivers that arm ready on a valid rising edge see a fresh edge per word.
- Flags links stalled longer than a programmable limit.

Parameters:
- DATA_WIDTH, 8, width of data words
- DEPTH, 4, FIFO entries; power of two, >=2
- GAP, 1, idle cycles with valid=0 after each transfer; 0 allows back-to-back beats
- TIMEOUT, 16, consecutive valid&&!ready cycles before stall_err sets; 0 disables the check

Ports:
- clk  input  1  clock, all flops on posedge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer word present
- in_ready  output  1  FIFO can accept; = !full && rst_n (combinational)
- in_data  input  DATA_WIDTH  producer word
- valid  output  1  link word valid (registered)
- ready  input  1  receiver accepts
- data  output  DATA_WIDTH  link word (registered)
- level  output  $clog2(DEPTH+1)  FIFO occupancy, excluding the word in the output register
- stall_err  output  1  sticky stall flag
- clr_err  input  1  clears stall_err

Behaviour:
- Reset (async assert, sync release): valid=0, data=0, FIFO empty, level=0, stall_err=0, state IDLE, counters 0.
  - Reset mid-transfer drops the word in flight and all buffered words.
- Push: occurs when in_valid && in_ready at posedge.
  - Full FIFO: in_ready=0 even if a pop happens the same cycle; no pass-through.
- Transfer: valid && ready at posedge.
  - data is stable while valid=1 and no transfer has occurred.
  - data=0 whenever valid=0.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if FIFO non-empty, pop head into data, set valid=1, go to SEND. Otherwise stay.
  - SEND, on transfer with GAP>0: valid=0, data=0, load gap_cnt=GAP-1, go to GAP.
  - SEND, on transfer with GAP=0: if FIFO non-empty, pop the next word into data, keep valid=1, stay. Else valid=0, go to IDLE.
  - SEND, no transfer: hold.
  - GAP: decrement gap_cnt. At 0, apply the IDLE rule that same edge, so valid=0 lasts exactly GAP cycles.
- Latency: word pushed at edge N into an empty IDLE block gives valid=1 after edge N+1.
- Simultaneous push and pop: level unchanged; pointers wrap modulo DEPTH.
- Stall counter:
  - Increments each cycle valid && !ready; saturates at TIMEOUT.
  - Clears on transfer or when valid=0.
  - stall_err sets when the count reaches TIMEOUT.
  - clr_err=1 clears stall_err; if clear and set coincide, set wins.
- ready is ignored while valid=0.

Optional Feature:
- Macro: VR_XMIT_STATS_EN.
- Defined: adds outputs xfer_count[31:0] (increments per transfer) and stall_cycles[31:0] (increments per valid && !ready cycle). Both wrap at 2^32, reset to 0, and clear on clr_err.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package vr_xmit_pkg:
  - xmit_state_e enum {IDLE, SEND, GAP}
  - localparam-style width helper function (clog2-based) for level/counter widths
- Sub-module vr_fifo: synchronous FIFO with push/pop/full/empty/level, async active-low reset.
- vr_transmitter contains the FSM, output register, gap and stall logic.

Test Plan:
- Reset then push 0xA5 with ready tied 1, GAP=1 -> valid rises the cycle after the push, data=0xA5 for one cycle, then valid=0 for exactly 1 cycle, level returns to 0.
- GAP=0, push 0x01..0x04 back-to-back, ready=1 -> four consecutive valid cycles carrying 01,02,03,04, then valid=0.
- DEPTH=4, ready=0, push 6 words -> in_ready=0 after the 5th push (4 in FIFO + 1 in output register), level=4, data holds the first word unchanged.
- ready=0 for 16 cycles with valid=1, TIMEOUT=16 -> stall_err=1 at the 16th stall cycle and stays set after the transfer; clr_err pulse -> 0.
- Assert rst_n=0 mid-SEND with 3 words buffered -> valid=0, data=0, level=0 immediately, no word emitted after release until new pushes.
- With VR_XMIT_STATS_EN, 5 transfers with 3 stall cycles -> xfer_count=5, stall_cycles=3; clr_err -> both 0.
